// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity sense constants and the 2-of-3 voter.
// Latency: none (constants and a combinational function); backpressure: not applicable.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops set on reset so an idle-high line reads idle.
// Latency: 2 clk; backpressure: none.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF sync, 3-sample mid-bit vote, false-start reject, parity/framing flags.
// Latency: rx_done at mid last stop bit (+2 clk sync); backpressure: none, rx_done is a 1-clk pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S3  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic                 rxs;
  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic [2:0]           samp;
  logic [DATA_BITS-1:0] sreg;
  logic                 perr_q;
  logic                 ferr_q;

  logic at_s3;
  logic at_end;
  logic vote_mid;
  logic vote_full;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rxs)
  );

  assign at_s3  = b_tick && (tcnt == T_S3);
  assign at_end = b_tick && (tcnt == T_END);
  // At sample 3 the third vote is the live rxs, so the decision does not wait a cycle.
  assign vote_mid  = maj3({rxs, samp[1:0]});
  assign vote_full = maj3(samp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp <= 3'b000;
    end else if (b_tick && (state != ST_IDLE)) begin
      if (tcnt == T_S1) samp[0] <= rxs;
      if (tcnt == T_S2) samp[1] <= rxs;
      if (tcnt == T_S3) samp[2] <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      sreg       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data    <= '0;
      rx_busy    <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (b_tick && (state != ST_IDLE)) tcnt <= tcnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state   <= ST_START;
            tcnt    <= '0;
            bcnt    <= '0;
            scnt    <= 1'b0;
            ferr_q  <= 1'b0;
            rx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (at_s3 && vote_mid) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end else if (at_end) begin
            state <= ST_DATA;
            tcnt  <= '0;
          end
        end

        ST_DATA: begin
          if (at_end) begin
            sreg <= {vote_full, sreg[DATA_BITS-1:1]};
            tcnt <= '0;
            bcnt <= bcnt + 1'b1;
            if (bcnt == B_LAST) state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end

        ST_PARITY: begin
          if (at_end) begin
            perr_q <= (^sreg) ^ vote_full ^ PAR_SENSE;
            tcnt   <= '0;
            state  <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (at_s3) begin
            if (scnt == S_LAST) begin
              // Leave mid-bit so a start edge right after the stop bit is still caught.
              state      <= ST_IDLE;
              rx_busy    <= 1'b0;
              rx_done    <= 1'b1;
              rx_data    <= sreg;
              parity_err <= (PARITY_EN != 0) && perr_q;
              frame_err  <= ferr_q | ~vote_mid;
            end else begin
              ferr_q <= ferr_q | ~vote_mid;
            end
          end else if (at_end) begin
            scnt <= 1'b1;
            tcnt <= '0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset_n) rx_done |-> !rx_busy);
  a_done_one_clk:  assert property (@(posedge clk) disable iff (!reset_n) rx_done |=> !rx_done);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg across five parameter sets sharing one b_tick (every 4 clk).
module tb_uart_rx_cfg;

  localparam int NDUT    = 5;
  localparam int BIT_CLK = 64;
  localparam int NB[NDUT] = '{8, 8, 8, 9, 5};
  localparam int PE[NDUT] = '{0, 1, 0, 0, 1};
  localparam int PO[NDUT] = '{0, 0, 0, 0, 1};
  localparam int NS[NDUT] = '{1, 1, 2, 1, 2};

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic b_tick = 1'b0;
  logic rx_line [NDUT];
  logic [8:0] data_o [NDUT];
  logic busy_o [NDUT];
  logic done_o [NDUT];
  logic perr_o [NDUT];
  logic ferr_o [NDUT];
  logic prev_done [NDUT];
  logic [7:0] d0, d1, d2;
  logic [8:0] d3;
  logic [4:0] d4;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  logic [8:0] exp_last0;

  assign data_o[0] = {1'b0, d0};
  assign data_o[1] = {1'b0, d1};
  assign data_o[2] = {1'b0, d2};
  assign data_o[3] = d3;
  assign data_o[4] = {4'b0, d4};

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .b_tick(b_tick), .rx(rx_line[0]), .rx_data(d0),
    .rx_busy(busy_o[0]), .rx_done(done_o[0]), .parity_err(perr_o[0]), .frame_err(ferr_o[0]));
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .b_tick(b_tick), .rx(rx_line[1]), .rx_data(d1),
    .rx_busy(busy_o[1]), .rx_done(done_o[1]), .parity_err(perr_o[1]), .frame_err(ferr_o[1]));
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .b_tick(b_tick), .rx(rx_line[2]), .rx_data(d2),
    .rx_busy(busy_o[2]), .rx_done(done_o[2]), .parity_err(perr_o[2]), .frame_err(ferr_o[2]));
  uart_rx_cfg #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u3 (
    .clk(clk), .reset_n(reset_n), .b_tick(b_tick), .rx(rx_line[3]), .rx_data(d3),
    .rx_busy(busy_o[3]), .rx_done(done_o[3]), .parity_err(perr_o[3]), .frame_err(ferr_o[3]));
  uart_rx_cfg #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
    .clk(clk), .reset_n(reset_n), .b_tick(b_tick), .rx(rx_line[4]), .rx_data(d4),
    .rx_busy(busy_o[4]), .rx_done(done_o[4]), .parity_err(perr_o[4]), .frame_err(ferr_o[4]));

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 b_tick = 1'b1;
    @(posedge clk);
    #1 b_tick = 1'b0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a frame's outcome from word value, parity bit and stop bits.
  function automatic exp_t model(input int idx, input logic [8:0] data, input logic pbit,
                                 input logic s0, input logic s1);
    exp_t e;
    int   ones;
    e.idx  = idx;
    e.data = 9'(int'(data) % (1 << NB[idx]));
    ones   = $countones(e.data) + int'(pbit);
    e.perr = (PE[idx] != 0) ? ((ones % 2) != PO[idx]) : 1'b0;
    e.ferr = (s0 == 1'b0) || (NS[idx] == 2 && s1 == 1'b0);
    return e;
  endfunction

  task automatic drive_bit(input int idx, input logic v, input bit spike, input bit chk_busy);
    @(posedge clk);
    #1 rx_line[idx] = v;
    for (int c = 1; c < BIT_CLK; c++) begin
      @(posedge clk);
      #1;
      if (spike && c == 36) rx_line[idx] = ~v;
      if (spike && c == 40) rx_line[idx] = v;
      if (chk_busy && c == 32) chk("busy_mid_start", busy_o[idx], 1'b1);
    end
  endtask

  task automatic send(input int idx, input logic [8:0] data, input logic pbit, input logic s0,
                      input logic s1, input bit push, input int spike_bit, input int gap);
    int g;
    g = gap;
    if (push) sb.push_back(model(idx, data, pbit, s0, s1));
    drive_bit(idx, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NB[idx]; i++) drive_bit(idx, data[i], (i == spike_bit), 1'b0);
    if (PE[idx] != 0) drive_bit(idx, pbit, 1'b0, 1'b0);
    drive_bit(idx, s0, 1'b0, 1'b0);
    if (NS[idx] == 2) drive_bit(idx, s1, 1'b0, 1'b0);
    // A low last stop bit looks like a start edge; leave room for it to be rejected.
    if ((s0 == 1'b0 || (NS[idx] == 2 && s1 == 1'b0)) && g < 128) g = 128;
    if (g > 0) begin
      @(posedge clk);
      #1 rx_line[idx] = 1'b1;
      repeat (g - 1) @(posedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      chk({tag, "_data"}, data_o[i], 0);
      chk({tag, "_busy"}, busy_o[i], 0);
      chk({tag, "_done"}, done_o[i], 0);
      chk({tag, "_perr"}, perr_o[i], 0);
      chk({tag, "_ferr"}, ferr_o[i], 0);
    end
  endtask

  function automatic logic rnd_stop();
    return ($urandom_range(0, 3) != 0);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (done_o[i] === 1'b1) begin
        chk("done_width", prev_done[i], 1'b0);
        chk("busy_at_done", busy_o[i], 1'b0);
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: dut %0d got rx_done expected none", i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dut_idx", i, e.idx);
          chk("rx_data", data_o[i], e.data);
          chk("parity_err", perr_o[i], e.perr);
          chk("frame_err", ferr_o[i], e.ferr);
        end
      end
      prev_done[i] = done_o[i];
    end
  end

  initial begin
    logic [8:0] d;
    logic       p;
    logic       s0;
    logic       s1;

    reset_n = 1'b0;
    for (int i = 0; i < NDUT; i++) rx_line[i] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // 8N1 basic frame, then random words with random idle gaps
    send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b1, -1, 20);
    exp_last0 = 9'h0A5;
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 255));
      send(0, d, 1'b0, 1'b1, 1'b1, 1'b1, -1, $urandom_range(0, 40));
      exp_last0 = d;
    end
    repeat (40) @(posedge clk);

    // Start glitch lasting 5 b_ticks must be rejected
    @(posedge clk);
    #1 rx_line[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("glitch_busy_high", busy_o[0], 1'b1);
    repeat (10) @(posedge clk);
    #1 rx_line[0] = 1'b1;
    repeat (100) @(posedge clk);
    #2 chk("glitch_busy_low", busy_o[0], 1'b0);
    chk("glitch_data_held", data_o[0], exp_last0);

    // Single-tick spike in mid data bit 3 is outvoted
    send(0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 3, 20);

    // Even parity: 0x37 has five ones
    send(1, 9'h037, 1'b1, 1'b1, 1'b1, 1'b1, -1, 20);
    send(1, 9'h037, 1'b0, 1'b1, 1'b1, 1'b1, -1, 20);
    for (int k = 0; k < 4; k++) begin
      d = 9'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      send(1, d, p, 1'b1, 1'b1, 1'b1, -1, $urandom_range(0, 40));
    end

    // Two stop bits: bad second stop, then clean frame clears the flag
    send(2, 9'h05A, 1'b0, 1'b1, 1'b0, 1'b1, -1, 20);
    send(2, 9'h001, 1'b0, 1'b1, 1'b1, 1'b1, -1, 20);
    for (int k = 0; k < 4; k++) begin
      d  = 9'($urandom_range(0, 255));
      s0 = rnd_stop();
      s1 = rnd_stop();
      send(2, d, 1'b0, s0, s1, 1'b1, -1, $urandom_range(0, 40));
    end

    // Nine data bits, back-to-back with zero idle
    send(3, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
    send(3, 9'h100, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
    for (int k = 0; k < 4; k++) begin
      d = 9'($urandom_range(0, 511));
      send(3, d, 1'b0, 1'b1, 1'b1, 1'b1, -1, $urandom_range(0, 40));
    end

    // Five data bits, odd parity, two stop bits, all fields random
    for (int k = 0; k < 5; k++) begin
      d  = 9'($urandom_range(0, 31));
      p  = 1'($urandom_range(0, 1));
      s0 = rnd_stop();
      s1 = rnd_stop();
      send(4, d, p, s0, s1, 1'b1, -1, $urandom_range(0, 40));
    end

    // Reset in the middle of the data bits abandons the frame
    fork
      send(0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
      begin
        repeat (4 * BIT_CLK) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset_mid");
      end
    join
    @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (200) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
